// File: rtl/mux2_arb_pkg.sv
// Shared types and source indices for the two-way round-robin mux arbiter.
package mux2_arb_pkg;

   typedef enum logic {EMPTY, FULL} arb_state_t;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the source other than
// last wins, otherwise the only requesting source wins.
module rr_pick2
   import mux2_arb_pkg::*;
(
   input  logic [1:0] in_valid,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |in_valid;
      gnt_idx   = SRC0;
      if (&in_valid) begin
         gnt_idx = ~last;
      end else if (in_valid[1]) begin
         gnt_idx = SRC1;
      end
   end

endmodule

// File: rtl/mux2_arb.sv
// Round-robin arbiter steering two valid/ready sources through a 2:1 select
// into a single-entry output register. Optional grant counters: MUX2_ARB_CNT_EN.
module mux2_arb
   import mux2_arb_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       in_valid,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   output logic [1:0]       in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   // Handshake: a word moves on any edge where valid and ready are both high.
   // in_ready may look at in_valid; in_valid must never look at in_ready.

   arb_state_t state, state_nxt;
   logic       last;
   logic       gnt_valid;
   logic       gnt_idx;
   logic       load;
   logic       xfer;

   rr_pick2 u_pick (
      .in_valid  (in_valid),
      .last      (last),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Gated by reset_n so no handshake completes while reset is held.
   assign load = reset_n && ((state == EMPTY) || out_ready);
   assign xfer = load && gnt_valid;

   always_comb begin
      in_ready  = 2'b00;
      state_nxt = state;
      if (xfer) begin
         in_ready  = (gnt_idx == SRC1) ? 2'b10 : 2'b01;
         state_nxt = FULL;
      end else if ((state == FULL) && out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= EMPTY;
         last     <= SRC1;
         out_data <= '0;
         out_src  <= SRC0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            out_data <= (gnt_idx == SRC1) ? in_data1 : in_data0;
            out_src  <= gnt_idx;
            last     <= gnt_idx;
         end
      end
   end

   assign out_valid = (state == FULL);

`ifdef MUX2_ARB_CNT_EN
   logic [CNT_W-1:0] cnt0, cnt1;

   // Saturating counters; only reset clears them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (xfer) begin
         if ((gnt_idx == SRC0) && !(&cnt0)) cnt0 <= cnt0 + 1'b1;
         if ((gnt_idx == SRC1) && !(&cnt1)) cnt1 <= cnt1 + 1'b1;
      end
   end

   assign gnt_cnt0 = cnt0;
   assign gnt_cnt1 = cnt1;
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mux2_arb.sv
// Directed bench for mux2_arb: reset, alternation, backpressure, single
// source, asynchronous reset mid-stream and the optional grant counters.
module tb_mux2_arb;

   localparam int WIDTH = 4;
   localparam int CNT_W = 2;

   logic             clk;
   logic             reset_n;
   logic [1:0]       in_valid;
   logic [WIDTH-1:0] in_data0;
   logic [WIDTH-1:0] in_data1;
   logic [1:0]       in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready;
   logic [CNT_W-1:0] gnt_cnt0;
   logic [CNT_W-1:0] gnt_cnt1;

   int tests_run;
   int tests_failed;

   mux2_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .gnt_cnt0  (gnt_cnt0),
      .gnt_cnt1  (gnt_cnt1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [3:0] d0, input logic [3:0] d1,
                        input logic ordy);
      in_valid  = v;
      in_data0  = d0;
      in_data1  = d1;
      out_ready = ordy;
      #1;
   endtask

   logic [3:0] exp_data [6];
   logic       exp_src  [6];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_data = '{4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC};
      exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      // 1. reset with random inputs
      reset_n   = 1'b0;
      in_valid  = 2'($urandom_range(0, 3));
      in_data0  = 4'($urandom_range(0, 15));
      in_data1  = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      repeat (3) step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_src",   32'(out_src),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_cnt0",      32'(gnt_cnt0),  32'd0);
      check("rst_cnt1",      32'(gnt_cnt1),  32'd0);
      reset_n = 1'b1;
      drive(2'b11, 4'h3, 4'hC, 1'b1);
      check("first_tie_ready", 32'(in_ready), 32'b01);

      // 2. alternation
      for (int i = 0; i < 6; i++) begin
         step();
         check("alt_valid", 32'(out_valid), 32'd1);
         check("alt_data",  32'(out_data),  32'(exp_data[i]));
         check("alt_src",   32'(out_src),   32'(exp_src[i]));
      end

      // 3. backpressure: load 0xA from source 0, then stall
      drive(2'b01, 4'hA, 4'hC, 1'b1);
      step();
      check("bp_load_data", 32'(out_data), 32'hA);
      drive(2'b11, 4'h3, 4'hC, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", 32'(in_ready), 32'b00);
         step();
         check("bp_data",  32'(out_data),  32'hA);
         check("bp_valid", 32'(out_valid), 32'd1);
      end
      drive(2'b11, 4'h3, 4'hC, 1'b1);
      check("bp_release_ready", 32'(in_ready), 32'b10);
      step();
      check("bp_release_data", 32'(out_data), 32'hC);
      check("bp_release_src",  32'(out_src),  32'd1);

      // 4. single source, then tie
      drive(2'b10, 4'h3, 4'h7, 1'b1);
      check("single_ready", 32'(in_ready), 32'b10);
      step();
      check("single_data", 32'(out_data), 32'h7);
      check("single_src",  32'(out_src),  32'd1);
      drive(2'b11, 4'h3, 4'h7, 1'b1);
      check("tie_ready", 32'(in_ready), 32'b01);
      step();
      check("tie_data", 32'(out_data), 32'h3);
      check("tie_src",  32'(out_src),  32'd0);

      // drain to EMPTY with no requests
      drive(2'b00, 4'h3, 4'h7, 1'b1);
      check("idle_ready", 32'(in_ready), 32'b00);
      step();
      check("drain_valid", 32'(out_valid), 32'd0);

      // 5. async reset mid-stream (leave last=0 first)
      drive(2'b01, 4'h5, 4'h7, 1'b0);
      step();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid",    32'(out_valid), 32'd0);
      check("arst_data",     32'(out_data),  32'd0);
      check("arst_src",      32'(out_src),   32'd0);
      check("arst_in_ready", 32'(in_ready),  32'b00);
      #1;
      reset_n = 1'b1;
      drive(2'b11, 4'h5, 4'h7, 1'b1);
      check("post_rst_tie", 32'(in_ready), 32'b01);

      // 6. grant counters
      drive(2'b01, 4'h1, 4'h7, 1'b1);
      for (int i = 0; i < 5; i++) step();
`ifdef MUX2_ARB_CNT_EN
      check("cnt0_sat", 32'(gnt_cnt0), 32'd3);
`else
      check("cnt0_off", 32'(gnt_cnt0), 32'd0);
`endif
      check("cnt1", 32'(gnt_cnt1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mux2_arb.md
Name: mux2_arb

Overview:
- Round-robin arbiter that shares one 2:1 data select path between two requesters with valid/ready handshakes.
- Two upstream sources present WIDTH-bit words. The block grants one source per accept, steers it through the select, and registers it into a single-entry output stage toward one downstream consumer.
- It is the controller that drives the mux select line, so the select is never driven ad hoc.

Parameters:
- WIDTH, 4: data word width in bits.
- CNT_W, 8: width of the grant counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  2  per-source valid; bit i belongs to source i.
- in_data0  input  WIDTH  source 0 word.
- in_data1  input  WIDTH  source 1 word.
- in_ready  output  2  per-source ready; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  1  source index of out_data.
- out_ready  input  1  downstream accepts the word.
- gnt_cnt0  output  CNT_W  source 0 grant count (optional feature).
- gnt_cnt1  output  CNT_W  source 1 grant count (optional feature).

Behaviour:
- One clock, clk; reset is asynchronous, active-low, on reset_n. Assertion takes effect immediately, without waiting for a clk edge.
- Reset values:
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer last=1, so source 0 wins the first tie.
  - gnt_cnt0 and gnt_cnt1 = 0.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = EMPTY or (FULL and out_ready).
- Grant (combinational):
  - Only in_valid[i] set: grant i.
  - Both set: grant the source other than last.
  - Neither set: no grant.
- in_ready[i] = load and grant==i.
  - in_ready may depend on in_valid; in_valid must never depend on in_ready.
- Transfer on source i = in_valid[i] and in_ready[i] at a clk edge. On that edge:
  - out_data <= in_data(i), out_src <= i, last <= i, state <= FULL.
- Transitions:
  - EMPTY → FULL on any transfer.
  - FULL → EMPTY when out_ready=1 and no transfer.
  - FULL → FULL on simultaneous drain and refill. Drain and refill happen in the same cycle, giving a bubble-free stream.
- Latency: 1 cycle from input transfer to out_valid.
  - Sustained throughput: 1 word/cycle when out_ready stays high.
- Held state:
  - FULL with out_ready=0: out_data and out_src hold stable, both in_ready are 0, last is unchanged.
  - last changes only on a transfer; idle cycles do not rotate priority.
- Fairness: with both sources continuously valid and out_ready high, grants alternate 0,1,0,1,…
- Reset mid-operation: the held word is discarded, outputs return to reset values, and no handshake completes in that cycle.

Optional Feature:
- Macro: MUX2_ARB_CNT_EN.
- Defined:
  - gnt_cnt0 increments on each source 0 transfer; gnt_cnt1 likewise for source 1.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - Both are cleared by reset_n only.
- Not defined: the ports still exist, are tied to 0, and no counter flops are built.

Decomposition:
- Package mux2_arb_pkg holds:
  - typedef enum logic {EMPTY, FULL} arb_state_t;
  - localparam SRC0=1'b0, SRC1=1'b1.
- One sub-module: rr_pick2. It is purely combinational.
  - Inputs: in_valid[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
  - It is reusable by later 2-way arbiters.
- The data select is a ternary on gnt_idx inside mux2_arb; there is no separate datapath instance.

Test Plan:
1. Reset: hold reset_n=0 with random inputs → out_valid=0, out_data=0, out_src=0, in_ready=2'b00. Release reset; first tie with in_valid=2'b11 grants source 0 (in_ready=2'b01).
2. Alternation: in_valid=2'b11, in_data0=4'h3, in_data1=4'hC, out_ready=1 for 6 cycles → out_data sequence 3,C,3,C,3,C; out_src 0,1,0,1,0,1; out_valid=1 from cycle 2 onward.
3. Backpressure: FULL with out_data=4'hA, out_ready=0 for 5 cycles while in_valid=2'b11 → out_data stays 4'hA and in_ready=2'b00 throughout. Raise out_ready → next word loads the following cycle.
4. Single source: in_valid=2'b10, in_data1=4'h7 → in_ready=2'b10; next cycle out_data=7, out_src=1. Then a tie → source 0 is granted.
5. Async reset mid-stream: assert reset_n between clk edges while FULL → out_valid drops immediately, before the next edge. After release the pointer is back at last=1.
6. With MUX2_ARB_CNT_EN and CNT_W=2: 5 source 0 transfers → gnt_cnt0=3 (saturated), gnt_cnt1=0. Without the macro → both read 0.
